// File: rtl/prefetch_fetch_queue_pkg.sv
// prefetch_fetch_queue_pkg: shared widths, reset PC and queue entry type
// for the decoupled fetch front end.
package prefetch_fetch_queue_pkg;
    localparam int FQ_XLEN = 32;
    localparam int FQ_ILEN = 32;
    localparam int FQ_DEPTH = 4;
    localparam logic [FQ_XLEN-1:0] FQ_RESET_PC = '0;
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/prefetch_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush; flush wins over
// push and pop, and a pop on an empty queue is ignored.
module fetch_fifo
    import prefetch_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic          do_push, do_pop;
    always_comb begin
        empty   = count_q == '0;
        full    = count_q == (AW+1)'(DEPTH);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head_d  = flush ? '0 : head_q + AW'(do_pop);
        tail_d  = flush ? '0 : tail_q + AW'(do_push);
        count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        mem_d   = mem_q;
        if (do_push && !flush) mem_d[tail_q] = din;
        dout    = mem_q[head_q];
        count   = count_q;
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/prefetch_fetch_queue.sv
// prefetch_fetch_queue: sequential instruction prefetcher with one icache
// request in flight, feeding Decode through a small registered queue.
module prefetch_fetch_queue
    import prefetch_fetch_queue_pkg::*;
#(
    parameter int               XLEN     = FQ_XLEN,
    parameter int               ILEN     = FQ_ILEN,
    parameter int               DEPTH    = FQ_DEPTH,
    parameter logic [XLEN-1:0]  RESET_PC = FQ_RESET_PC
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     ic_req,
    output logic [XLEN-1:0]          ic_addr,
    input  logic                     ic_ready,
    input  logic                     ic_rvalid,
    input  logic [ILEN-1:0]          ic_rdata,
    output logic                     dec_valid,
    output logic [ILEN-1:0]          dec_instr,
    output logic [XLEN-1:0]          dec_pc,
    output logic [XLEN-1:0]          dec_pc4,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic            outst_q, outst_d, drop_q, drop_d, armed_q, armed_d;
    logic            resp, accept, push, pop;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    head, entry;
    always_comb begin
        resp       = ic_rvalid & outst_q;
        // an in-flight request already owns a queue slot
        ic_req     = nrst & armed_q & ~redirect_valid & (~outst_q | ic_rvalid)
                     & ((fifo_count + CW'(outst_q)) < CW'(DEPTH));
        ic_addr    = fetch_pc_q;
        accept     = ic_req & ic_ready;
        dec_valid  = nrst & ~fifo_empty;
        dec_instr  = head.instr;
        dec_pc     = head.pc;
        dec_pc4    = head.pc + XLEN'(4);
        q_count    = nrst ? fifo_count : '0;
        push       = resp & ~drop_q & ~redirect_valid;
        pop        = dec_valid & dec_ready & ~redirect_valid;
        entry      = '{pc: req_pc_q, instr: ic_rdata};
        fetch_pc_d = redirect_valid ? redirect_pc & {{(XLEN-2){1'b1}}, 2'b00}
                   : accept ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        req_pc_d   = accept ? fetch_pc_q : req_pc_q;
        outst_d    = accept | (outst_q & ~ic_rvalid);
        drop_d     = redirect_valid ? outst_q & ~ic_rvalid : drop_q & ~resp;
        armed_d    = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            outst_q    <= 1'b0;
            drop_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            armed_q    <= armed_d;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    no_overflow: assert property (@(posedge clk) disable iff (!nrst) !(push && fifo_full && !pop));
endmodule

// File: tb/tb_prefetch_fetch_queue.sv
// tb_prefetch_fetch_queue: icache/decode environment with a queue-based
// reference model of the expected instruction stream.
module tb_prefetch_fetch_queue;
    logic        clk = 0, nrst = 0, redirect_valid = 0, ic_ready = 0, ic_rvalid = 0, dec_ready = 0;
    logic [31:0] redirect_pc = 0, ic_rdata = 0;
    logic        ic_req, dec_valid;
    logic [31:0] ic_addr, dec_instr, dec_pc, dec_pc4;
    logic [2:0]  q_count;

    prefetch_fetch_queue dut (
        .clk(clk), .nrst(nrst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_pc4(dec_pc4), .dec_ready(dec_ready), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] exp_fetch = 0, pend_addr = 0, hold_addr = 0, acc_addr_prev = 0;
    int          epoch = 0, pend_epoch = 0, pend_lat = 0, lat_lo = 1, lat_hi = 1;
    bit          pend = 0, dead = 0, hold = 0, acc_prev = 0;
    int          checks = 0, errors = 0, pops = 0;
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_instr;
    logic [2:0]  obs_count;

    function automatic logic [31:0] ifn(input logic [31:0] pc);
        return (pc * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic cycle(input bit rn, input bit dr, input bit ir, input bit rv, input logic [31:0] rpc);
        bit acc, dlv;
        logic [31:0] aaddr;
        @(negedge clk);
        nrst = rn; dec_ready = dr; ic_ready = ir; redirect_valid = rv; redirect_pc = rpc;
        if (pend && pend_lat > 0) pend_lat--;
        dlv = pend && pend_lat == 0;
        ic_rvalid = dlv;
        ic_rdata = dlv ? ifn(pend_addr) : $urandom;
        #1;
        obs_req = ic_req; obs_addr = ic_addr; obs_valid = dec_valid;
        obs_pc = dec_pc; obs_instr = dec_instr; obs_count = q_count;
        if (!rn || dead) begin
            checks++;
            if (ic_req !== 1'b0) begin errors++; $display("FAIL reset_ic_req: got %b expected 0", ic_req); end
        end
        if (!rn) begin
            checks++;
            if (dec_valid !== 1'b0 || q_count !== 3'd0) begin
                errors++; $display("FAIL reset_outputs: dec_valid=%b q_count=%0d expected 0/0", dec_valid, q_count);
            end
        end else begin
            checks++;
            if (dec_valid !== (mq.size() != 0) || q_count !== 3'(mq.size())) begin
                errors++; $display("FAIL occupancy: dec_valid=%b q_count=%0d expected %b/%0d", dec_valid, q_count, mq.size() != 0, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (dec_pc !== mq[0].pc || dec_instr !== mq[0].instr || dec_pc4 !== mq[0].pc + 32'd4) begin
                    errors++; $display("FAIL head: pc=%h instr=%h pc4=%h expected %h %h %h", dec_pc, dec_instr, dec_pc4, mq[0].pc, mq[0].instr, mq[0].pc + 32'd4);
                end
            end
            if (rv) begin
                checks++;
                if (ic_req !== 1'b0) begin errors++; $display("FAIL redirect_req: got %b expected 0", ic_req); end
            end
            if (hold && !rv) begin
                checks++;
                if (ic_req !== 1'b1 || ic_addr !== hold_addr) begin
                    errors++; $display("FAIL req_hold: req=%b addr=%h expected 1 %h", ic_req, ic_addr, hold_addr);
                end
            end
            if (ic_req === 1'b1 && pend && !dlv) begin
                checks++; errors++; $display("FAIL one_outstanding: req=1 expected 0 while %h pending", pend_addr);
            end
        end
        acc = rn && ic_req === 1'b1 && ir;
        aaddr = exp_fetch;
        if (acc) begin
            checks++;
            if (ic_addr !== exp_fetch) begin errors++; $display("FAIL fetch_addr: got %h expected %h", ic_addr, exp_fetch); end
        end
        if (!rn) begin
            mq.delete(); exp_fetch = 0; epoch++; dead = 1; hold = 0;
        end else begin
            dead = 0;
            if (rv) begin
                mq.delete(); epoch++; exp_fetch = rpc & ~32'd3;
            end else begin
                if (dr && mq.size() != 0) begin void'(mq.pop_front()); pops++; end
                if (dlv && pend_epoch == epoch) mq.push_back('{pend_addr, ifn(pend_addr)});
                if (mq.size() > 4) begin checks++; errors++; $display("FAIL overflow: size %0d expected <=4", mq.size()); end
                if (acc) exp_fetch += 32'd4;
            end
            hold = ic_req === 1'b1 && !ir && !rv;
            hold_addr = ic_addr;
        end
        if (dlv) pend = 0;
        if (acc) begin pend = 1; pend_lat = $urandom_range(lat_hi, lat_lo); pend_addr = aaddr; pend_epoch = epoch; end
        acc_prev = acc; acc_addr_prev = aaddr;
    endtask

    task automatic do_reset();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_stream();
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0);
        pops = 0;
        for (int i = 0; i < 20; i++) cycle(1, 1, 1, 0, 0);
        checks++;
        if (pops !== 20) begin errors++; $display("FAIL throughput: got %0d pops expected 20", pops); end
    endtask

    task automatic test_fill();
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 15; i++) cycle(1, 0, 1, 0, 0);
        checks++;
        if (obs_count !== 3'd4 || obs_req !== 1'b0 || obs_pc !== 32'h0) begin
            errors++; $display("FAIL fill: q_count=%0d req=%b head=%h expected 4 0 0", obs_count, obs_req, obs_pc);
        end
        for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 0);
    endtask

    task automatic test_redirect_drop();
        lat_lo = 2; lat_hi = 2;
        do_reset();
        for (int i = 0; i < 30 && !(acc_prev && acc_addr_prev == 32'h8); i++) cycle(1, 1, 1, 0, 0);
        checks++;
        if (!(acc_prev && acc_addr_prev == 32'h8)) begin errors++; $display("FAIL timeout_fetch8: got none expected accept of 8"); end
        cycle(1, 1, 1, 1, 32'h103);
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 20 && obs_valid !== 1'b1; i++) cycle(1, 1, 1, 0, 0);
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h100) begin
            errors++; $display("FAIL redirect_target: valid=%b pc=%h expected 1 00000100", obs_valid, obs_pc);
        end
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 0);
    endtask

    task automatic test_push_pop_near_full();
        lat_lo = 3; lat_hi = 3;
        do_reset();
        for (int i = 0; i < 60 && !(mq.size() == 3 && pend && pend_lat == 1); i++) cycle(1, 0, 1, 0, 0);
        checks++;
        if (!(mq.size() == 3 && pend && pend_lat == 1)) begin errors++; $display("FAIL timeout_near_full: got %0d entries expected 3", mq.size()); end
        cycle(1, 1, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        checks++;
        if (obs_count !== 3'd3) begin errors++; $display("FAIL push_pop_count: got %0d expected 3", obs_count); end
        for (int i = 0; i < 15; i++) cycle(1, 0, 1, 0, 0);
        checks++;
        if (obs_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", obs_count); end
        cycle(1, 1, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        checks++;
        if (obs_count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d expected 3", obs_count); end
        for (int i = 0; i < 20; i++) cycle(1, 1, 1, 0, 0);
    endtask

    task automatic test_icache_stall();
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 40 && exp_fetch != 32'h20; i++) cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 0, 0, 0);
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h20) begin
                errors++; $display("FAIL stall_hold: req=%b addr=%h expected 1 00000020", obs_req, obs_addr);
            end
        end
        for (int i = 0; i < 15; i++) cycle(1, 1, 1, 0, 0);
    endtask

    task automatic test_reset_inflight();
        lat_lo = 3; lat_hi = 3;
        do_reset();
        for (int i = 0; i < 10 && !acc_prev; i++) cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 20 && obs_valid !== 1'b1; i++) cycle(1, 1, 1, 0, 0);
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_instr !== ifn(32'h0)) begin
            errors++; $display("FAIL reset_inflight: valid=%b pc=%h instr=%h expected 1 00000000 %h", obs_valid, obs_pc, obs_instr, ifn(32'h0));
        end
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 0);
    endtask

    task automatic test_random();
        lat_lo = 1; lat_hi = 3;
        do_reset();
        cycle(1, 1, 1, 1, 32'hFFFF_FFF9);
        for (int i = 0; i < 3000; i++)
            cycle(1, $urandom_range(9, 0) < 7, $urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0, $urandom);
    endtask

    initial begin
        test_reset_stream();
        test_fill();
        test_redirect_drop();
        test_push_pop_near_full();
        test_icache_stall();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
